// File: rtl/bumpy_pkg.sv
// Shared types for the Bumpy sprite control path.
// Holds the state encoding consumed by the motion block, the collision
// bundle layout and the frame counter width.
package bumpy_pkg;

  // Width of the per-state frame counter
  localparam int unsigned CNT_W = 8;

  // Sprite state, shared with the downstream motion block
  typedef enum logic [3:0] {
    Sreset             = 4'd0,
    Sidle              = 4'd1,
    Sleft              = 4'd2,
    Sright             = 4'd3,
    Sdown              = 4'd4,
    Sup                = 4'd5,
    Sdie               = 4'd6,
    Sbounce_from_left  = 4'd7,
    Sbounce_from_right = 4'd8,
    Sbounce_from_top   = 4'd9
  } bumpy_state_t;

  // One bit per collision source
  typedef struct packed {
    logic hazard;
    logic top;
    logic right;
    logic left;
  } bumpy_col_t;

  // Codes 10..15 are not states and force a return to Sreset
  function automatic logic is_legal_state(input logic [3:0] s);
    return (s <= 4'd9);
  endfunction

endpackage

// File: rtl/bumpy_col_latch.sv
// Sticky collision latches for the Bumpy control FSM.
// Each collision pulse is remembered until the next frame tick. The output
// is the latch ORed with the live input, so a pulse arriving on the tick
// cycle itself is seen by that tick's decision and is then discarded.
module bumpy_col_latch
  import bumpy_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_resetN,
  input  logic       i_tick,
  input  bumpy_col_t i_col,
  output bumpy_col_t o_col_eff
);

  bumpy_col_t r_lat;

  // Set on any pulse, cleared on reset and on every frame tick
  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_lat <= '0;
    end else if (i_tick) begin
      r_lat <= '0;
    end else begin
      r_lat <= r_lat | i_col;
    end
  end

  // Decision view: remembered pulses plus anything arriving right now
  always_comb begin
    o_col_eff = r_lat | i_col;
  end

endmodule

// File: rtl/bumpy_state_ctrl.sv
// Per-frame control FSM for the Bumpy player sprite.
// Re-evaluates the sprite state once per startOfFrame tick from the keys and
// the latched collisions, and emits die_pulse on entry to Sdie.
// Optional build macro: BUMPY_KEY_DEBOUNCE_EN (keys must be held for two
// consecutive ticks before they count).
module bumpy_state_ctrl
  import bumpy_pkg::*;
#(
  parameter int unsigned RESET_FRAMES  = 2,
  parameter int unsigned BOUNCE_FRAMES = 8,
  parameter int unsigned DIE_FRAMES    = 30
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         startOfFrame,
  input  logic         key_left,
  input  logic         key_right,
  input  logic         key_up,
  input  logic         key_down,
  input  logic         col_left,
  input  logic         col_right,
  input  logic         col_top,
  input  logic         col_hazard,
  output bumpy_state_t state,
  output logic         die_pulse
);

  // Counter value seen on the last tick of each timed state
  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_FRAMES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_FRAMES - 1);
  localparam logic [CNT_W-1:0] DIE_LAST    = CNT_W'(DIE_FRAMES - 1);

  bumpy_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_die_pulse;

  bumpy_state_t     w_next;
  bumpy_col_t       w_col_live;
  bumpy_col_t       w_col_eff;
  logic [3:0]       w_key_raw;
  logic [3:0]       w_key_eff;
  logic             w_legal;

  // Key bundle order: {down, up, right, left}
  always_comb begin
    w_key_raw = {key_down, key_up, key_right, key_left};
  end

`ifdef BUMPY_KEY_DEBOUNCE_EN
  logic [3:0] r_key_prev;

  // Key history sampled on each tick; cleared by reset
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_key_prev <= '0;
    end else if (startOfFrame) begin
      r_key_prev <= w_key_raw;
    end
  end

  // A key counts only when high at this tick and the previous one
  always_comb begin
    w_key_eff = w_key_raw & r_key_prev;
  end
`else
  // Keys used exactly as sampled at the tick
  always_comb begin
    w_key_eff = w_key_raw;
  end
`endif

  // Collision bundle from the live pulse inputs
  always_comb begin
    w_col_live        = '0;
    w_col_live.left   = col_left;
    w_col_live.right  = col_right;
    w_col_live.top    = col_top;
    w_col_live.hazard = col_hazard;
  end

  bumpy_col_latch u_col_latch (
    .i_clk     (clk),
    .i_resetN  (resetN),
    .i_tick    (startOfFrame),
    .i_col     (w_col_live),
    .o_col_eff (w_col_eff)
  );

  always_comb begin
    w_legal = is_legal_state(r_state);
  end

  // Next-state decision, applied only when a frame tick arrives
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      Sreset: begin
        if (r_cnt == RESET_LAST) begin
          w_next = Sidle;
        end
      end
      Sidle, Sleft, Sright, Sup, Sdown: begin
        if (w_col_eff.hazard) begin
          w_next = Sdie;
        end else if (w_col_eff.left) begin
          w_next = Sbounce_from_left;
        end else if (w_col_eff.right) begin
          w_next = Sbounce_from_right;
        end else if (w_col_eff.top) begin
          w_next = Sbounce_from_top;
        end else if (w_key_eff[0]) begin
          w_next = Sleft;
        end else if (w_key_eff[1]) begin
          w_next = Sright;
        end else if (w_key_eff[2]) begin
          w_next = Sup;
        end else if (w_key_eff[3]) begin
          w_next = Sdown;
        end else begin
          w_next = Sidle;
        end
      end
      Sbounce_from_left, Sbounce_from_right, Sbounce_from_top: begin
        if (w_col_eff.hazard) begin
          w_next = Sdie;
        end else if (r_cnt == BOUNCE_LAST) begin
          w_next = Sidle;
        end
      end
      Sdie: begin
        if (r_cnt == DIE_LAST) begin
          w_next = Sreset;
        end
      end
      default: begin
        w_next = Sreset;
      end
    endcase
  end

  // State, frame counter and die pulse; illegal codes recover without a tick
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state     <= Sreset;
      r_cnt       <= '0;
      r_die_pulse <= 1'b0;
    end else if (!w_legal) begin
      r_state     <= Sreset;
      r_cnt       <= '0;
      r_die_pulse <= 1'b0;
    end else if (startOfFrame) begin
      r_state     <= w_next;
      r_cnt       <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_die_pulse <= (w_next == Sdie) && (r_state != Sdie);
    end else begin
      r_die_pulse <= 1'b0;
    end
  end

  assign state     = r_state;
  assign die_pulse = r_die_pulse;

endmodule

// File: tb/tb_bumpy_state_ctrl.sv
// Self-checking bench for bumpy_state_ctrl: directed scenarios with fixed
// expectations, then randomized traffic against a frame-level model.
module tb_bumpy_state_ctrl;

  localparam int unsigned RESET_FRAMES  = 2;
  localparam int unsigned BOUNCE_FRAMES = 8;
  localparam int unsigned DIE_FRAMES    = 30;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic       col_left = 1'b0, col_right = 1'b0, col_top = 1'b0, col_hazard = 1'b0;
  logic [3:0] state;
  logic       die_pulse;

  int checks = 0;
  int errors = 0;

  // Frame-level model: current state, ticks already spent in it,
  // pending collisions and the key levels seen at the previous tick
  int m_state = 0;
  int m_ticks = 0;
  bit m_die = 0;
  bit m_pl = 0, m_pr = 0, m_pt = 0, m_ph = 0;
  bit [3:0] m_prev_keys = '0;

  always #5 clk = ~clk;

  bumpy_state_ctrl #(
    .RESET_FRAMES (RESET_FRAMES),
    .BOUNCE_FRAMES(BOUNCE_FRAMES),
    .DIE_FRAMES   (DIE_FRAMES)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_up      (key_up),
    .key_down    (key_down),
    .col_left    (col_left),
    .col_right   (col_right),
    .col_top     (col_top),
    .col_hazard  (col_hazard),
    .state       (state),
    .die_pulse   (die_pulse)
  );

  // Advance the model by one clock using the inputs about to be sampled
  task automatic model_update();
    bit hl, hr, ht, hh;
    bit [3:0] keys, k;
    int ns;
    if (!resetN) begin
      m_state = 0; m_ticks = 0; m_die = 0;
      m_pl = 0; m_pr = 0; m_pt = 0; m_ph = 0;
      m_prev_keys = '0;
    end else if (startOfFrame) begin
      hl = m_pl | col_left;  hr = m_pr | col_right;
      ht = m_pt | col_top;   hh = m_ph | col_hazard;
      keys = {key_down, key_up, key_right, key_left};
`ifdef BUMPY_KEY_DEBOUNCE_EN
      k = keys & m_prev_keys;
`else
      k = keys;
`endif
      ns = m_state;
      if (m_state == 0) begin
        if (m_ticks + 1 >= int'(RESET_FRAMES)) ns = 1;
      end else if (m_state >= 1 && m_state <= 5) begin
        if (hh) ns = 6;
        else if (hl) ns = 7;
        else if (hr) ns = 8;
        else if (ht) ns = 9;
        else if (k[0]) ns = 2;
        else if (k[1]) ns = 3;
        else if (k[2]) ns = 5;
        else if (k[3]) ns = 4;
        else ns = 1;
      end else if (m_state == 6) begin
        if (m_ticks + 1 >= int'(DIE_FRAMES)) ns = 0;
      end else begin
        if (hh) ns = 6;
        else if (m_ticks + 1 >= int'(BOUNCE_FRAMES)) ns = 1;
      end
      m_die = (ns == 6) && (m_state != 6);
      m_ticks = (ns == m_state) ? m_ticks + 1 : 0;
      m_state = ns;
      m_pl = 0; m_pr = 0; m_pt = 0; m_ph = 0;
      m_prev_keys = keys;
    end else begin
      m_die = 0;
      m_pl |= col_left; m_pr |= col_right; m_pt |= col_top; m_ph |= col_hazard;
    end
  endtask

  task automatic clk_step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  // Idle for gap cycles, then deliver one frame tick
  task automatic do_tick(input int gap);
    repeat (gap) clk_step();
    startOfFrame = 1'b1;
    clk_step();
    startOfFrame = 1'b0;
  endtask

  // Tick(s) needed for a held key to register in the current build
  task automatic press_tick();
`ifdef BUMPY_KEY_DEBOUNCE_EN
    do_tick(2);
`endif
    do_tick(2);
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) clk_step();
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", state);
    end
    checks++;
    if (die_pulse !== 1'b0) begin
      errors++; $display("FAIL reset_die: got %0b want 0", die_pulse);
    end
  endtask

  task automatic test_startup();
    resetN = 1'b1;
    do_tick(3);
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL startup_t1: got %0d want 0", state);
    end
    do_tick(3);
    checks++;
    if (state !== 4'd1) begin
      errors++; $display("FAIL startup_t2: got %0d want 1", state);
    end
  endtask

  task automatic test_keys();
    key_left = 1'b1; key_up = 1'b1;
    press_tick();
    checks++;
    if (state !== 4'd2) begin
      errors++; $display("FAIL key_priority: got %0d want 2", state);
    end
    key_left = 1'b0; key_up = 1'b0;
    do_tick(2);
    checks++;
    if (state !== 4'd1) begin
      errors++; $display("FAIL key_release: got %0d want 1", state);
    end
  endtask

  task automatic test_wall_bounce();
    key_left = 1'b1;
    press_tick();
    checks++;
    if (state !== 4'd2) begin
      errors++; $display("FAIL bounce_pre: got %0d want 2", state);
    end
    key_left = 1'b0;
    col_left = 1'b1; clk_step(); col_left = 1'b0;
    do_tick(99);
    checks++;
    if (state !== 4'd7) begin
      errors++; $display("FAIL bounce_enter: got %0d want 7", state);
    end
    for (int i = 1; i < int'(BOUNCE_FRAMES); i++) begin
      if (i == 3) begin
        col_right = 1'b1; clk_step(); col_right = 1'b0;
      end
      do_tick(4);
      checks++;
      if (state !== 4'd7) begin
        errors++; $display("FAIL bounce_hold_%0d: got %0d want 7", i, state);
      end
    end
    do_tick(4);
    checks++;
    if (state !== 4'd1) begin
      errors++; $display("FAIL bounce_exit: got %0d want 1", state);
    end
  endtask

  task automatic test_hazard_die();
    col_top = 1'b1; clk_step(); col_top = 1'b0;
    do_tick(2);
    checks++;
    if (state !== 4'd9) begin
      errors++; $display("FAIL top_bounce: got %0d want 9", state);
    end
    repeat (3) clk_step();
    startOfFrame = 1'b1; col_hazard = 1'b1;
    clk_step();
    startOfFrame = 1'b0; col_hazard = 1'b0;
    checks++;
    if (state !== 4'd6) begin
      errors++; $display("FAIL die_enter: got %0d want 6", state);
    end
    checks++;
    if (die_pulse !== 1'b1) begin
      errors++; $display("FAIL die_pulse_hi: got %0b want 1", die_pulse);
    end
    clk_step();
    checks++;
    if (die_pulse !== 1'b0) begin
      errors++; $display("FAIL die_pulse_width: got %0b want 0", die_pulse);
    end
    for (int i = 1; i < int'(DIE_FRAMES); i++) begin
      do_tick(2);
      checks++;
      if (state !== 4'd6 || die_pulse !== 1'b0) begin
        errors++; $display("FAIL die_hold_%0d: got %0d/%0b want 6/0", i, state, die_pulse);
      end
    end
    do_tick(2);
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL die_exit: got %0d want 0", state);
    end
    do_tick(2);
    do_tick(2);
    checks++;
    if (state !== 4'd1) begin
      errors++; $display("FAIL die_recover: got %0d want 1", state);
    end
  endtask

  task automatic test_reset_mid_die();
    col_hazard = 1'b1; clk_step(); col_hazard = 1'b0;
    do_tick(2);
    checks++;
    if (state !== 4'd6) begin
      errors++; $display("FAIL mid_die_enter: got %0d want 6", state);
    end
    repeat (10) do_tick(2);
    col_left = 1'b1; clk_step(); col_left = 1'b0;
    resetN = 1'b0; clk_step(); resetN = 1'b1;
    checks++;
    if (state !== 4'd0 || die_pulse !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got %0d/%0b want 0/0", state, die_pulse);
    end
    do_tick(2);
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL mid_reset_t1: got %0d want 0", state);
    end
    do_tick(2);
    checks++;
    if (state !== 4'd1) begin
      errors++; $display("FAIL mid_reset_t2: got %0d want 1", state);
    end
    do_tick(2);
    checks++;
    if (state !== 4'd1) begin
      errors++; $display("FAIL latch_cleared: got %0d want 1", state);
    end
  endtask

  task automatic test_key_sampling();
    key_right = 1'b1;
    do_tick(2);
    key_right = 1'b0;
    checks++;
`ifdef BUMPY_KEY_DEBOUNCE_EN
    if (state !== 4'd1) begin
      errors++; $display("FAIL glitch_key: got %0d want 1", state);
    end
`else
    if (state !== 4'd3) begin
      errors++; $display("FAIL single_key: got %0d want 3", state);
    end
`endif
    do_tick(2);
    checks++;
    if (state !== 4'd1) begin
      errors++; $display("FAIL key_drop: got %0d want 1", state);
    end
    key_right = 1'b1;
    do_tick(2);
    do_tick(2);
    key_right = 1'b0;
    checks++;
    if (state !== 4'd3) begin
      errors++; $display("FAIL held_key: got %0d want 3", state);
    end
    do_tick(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6000; i++) begin
      resetN       = ($urandom_range(0, 999) != 0);
      startOfFrame = ($urandom_range(0, 5) == 0);
      col_left     = ($urandom_range(0, 24) == 0);
      col_right    = ($urandom_range(0, 24) == 0);
      col_top      = ($urandom_range(0, 24) == 0);
      col_hazard   = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) == 0) begin
        {key_down, key_up, key_right, key_left} = 4'($urandom_range(0, 15));
      end
      clk_step();
      checks++;
      if (state !== 4'(m_state) || die_pulse !== m_die) begin
        errors++;
        $display("FAIL random_%0d: got %0d/%0b want %0d/%0b", i, state, die_pulse, m_state, m_die);
      end
    end
    resetN = 1'b1; startOfFrame = 1'b0;
    col_left = 1'b0; col_right = 1'b0; col_top = 1'b0; col_hazard = 1'b0;
    {key_down, key_up, key_right, key_left} = 4'd0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_keys();
    test_wall_bounce();
    test_hazard_die();
    test_reset_mid_die();
    test_key_sampling();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
